touch_scan_ctrl: RTL
====================

Name: touch_scan_ctrl

Overview:
- Autonomous scan sequencer for the LT24 resistive touch controller (ADS7843-compatible SPI ADC).
- Waits for the pen-down interrupt, debounces it, then repeatedly runs X and Y conversion frames over SPI while the pen stays down.
- Publishes 12-bit coordinates with a valid strobe.
- Sits between the touch panel pins and a CPU-visible register/PIO slave, replacing software bit-banging of the SPI core.

Parameters:
- CLK_DIV, 25, system clocks per SCLK half-period (50 MHz / 50 = 1 MHz SCLK); legal range 2..255.
- DEBOUNCE_CYC, 50000, consecutive clocks pen_irq_n must stay low before scanning (1 ms).
- SCAN_GAP_CYC, 500000, idle clocks between X/Y pairs while pen is down (10 ms).
- CMD_X, 8'h90, command byte for the X conversion (12-bit, differential, power-down between conversions).
- CMD_Y, 8'hD0, command byte for the Y conversion.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  scanning permitted; low forces IDLE at the next frame boundary
- pen_irq_n  in  1  touch controller PENIRQ, active low; asynchronous
- spi_miso  in  1  touch controller DOUT
- spi_mosi  out  1  touch controller DIN
- spi_sclk  out  1  SPI clock, idle low
- spi_ss_n  out  1  chip select, active low
- pen_down  out  1  debounced pen state
- coord_x  out  12  last X result
- coord_y  out  12  last Y result
- coord_valid  out  1  one-cycle strobe: coord_x/coord_y updated as a pair
- busy  out  1  high whenever spi_ss_n is low

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - spi_ss_n=1, spi_sclk=0, spi_mosi=0
  - pen_down=0, coord_x=0, coord_y=0, coord_valid=0, busy=0
  - state=IDLE, all counters 0
- pen_irq_n passes through a 2-flop synchronizer before use; that adds 2 cycles of latency.
- States:
  - IDLE: if enable and sync pen low, go to DEBOUNCE.
  - DEBOUNCE: count while pen low. Pen high resets the counter and returns to IDLE. Count reaching DEBOUNCE_CYC sets pen_down=1 and goes to FRAME_X.
  - FRAME_X / FRAME_Y: one 24-SCLK frame each.
  - GAP: count SCAN_GAP_CYC, then re-check the pen. Pen still low and enable high: go to FRAME_X. Otherwise clear pen_down and go to IDLE.
- Frame timing:
  - ss_n falls, then one half-period elapses before the first SCLK rise.
  - Bits are indexed 0..23 by SCLK rising edge.
  - mosi carries the command byte MSB-first on bits 0..7 and 0 afterwards; it changes only while sclk is low.
  - miso is sampled on the rising edge of bits 9..20, MSB first, into a 12-bit shift register.
  - After the 24th falling edge, ss_n rises and is held high for at least one half-period before the next frame.
- Result update:
  - The X result is held internally.
  - At the end of FRAME_Y, coord_x and coord_y are loaded together and coord_valid pulses for exactly one cycle.
  - Latency from ss_n falling in FRAME_X to coord_valid: 2 frames (each 48*CLK_DIV cycles plus the ss_n guard intervals) plus 1 cycle.
- Pen lift during a frame: the frame always completes, because the SPI transaction is never truncated.
  - Lift during FRAME_X or FRAME_Y: the pair is discarded (no coord_valid) and the block goes to IDLE with pen_down cleared.
  - The pen is re-checked at the end of each frame.
- enable deasserted: the current frame completes, then the block goes to IDLE. pen_down clears, coord_x/y hold.
- Synchronous reset mid-frame: outputs return to reset values on the next edge, ss_n=1 immediately, no partial update.
- Divider: the counter runs 0..CLK_DIV-1, toggles sclk on wrap, and is enabled only in FRAME states.

Optional Feature:
- Macro: TOUCH_SCAN_AVG_EN.
- Defined:
  - Each pen-down period collects 4 consecutive X/Y pairs.
  - 14-bit accumulators sum each axis; the output is sum>>2, truncated.
  - coord_valid pulses once per 4 pairs.
  - A pen lift discards partial accumulators.
- Undefined: one pair per coord_valid, as above; accumulators are not synthesized.

Decomposition:
- Package touch_scan_pkg:
  - state enum (IDLE, DEBOUNCE, FRAME_X, FRAME_Y, GAP)
  - FRAME_BITS=24, DATA_MSB_BIT=9, DATA_LSB_BIT=20
  - 12-bit coordinate typedef
- Sub-module spi_frame24: takes start, cmd[7:0], CLK_DIV; drives sclk/mosi/ss_n, samples miso; returns done and data[11:0]. The top holds the FSM, debounce, gap and averaging.

Test Plan:
- Debounce reject: pen_irq_n low for DEBOUNCE_CYC-10 cycles, then high. Required: ss_n never falls, pen_down=0.
- Single pair: pen held low; model returns X=12'hA5C, Y=12'h3F1. Required:
  - MOSI shows 8'h90 then 8'hD0
  - exactly 24 SCLK rises per frame
  - coord_valid one cycle with coord_x=A5C, coord_y=3F1
- Boundary data: model returns 12'h000 and 12'hFFF. Required: outputs exact; bits 21..23 ignored even when miso=1.
- Lift mid-FRAME_Y: pen high at bit 5 of the Y frame. Required: frame finishes to 24 bits, no coord_valid, pen_down=0, IDLE.
- Reset mid-frame: reset asserted at bit 12 for 1 cycle. Required: next cycle ss_n=1, sclk=0, coord_x/y=0; restart needs a full debounce.
- TOUCH_SCAN_AVG_EN: X samples 100, 101, 102, 104. Required: single coord_valid after the 4th pair, coord_x=101.

Source files
------------

// File: rtl/touch_scan_pkg.sv
// Shared types and frame constants for the LT24 touch scan sequencer.
package touch_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        FRAME_X,
        FRAME_Y,
        GAP
    } state_e;

    localparam int unsigned FRAME_BITS   = 24;
    localparam int unsigned DATA_MSB_BIT = 9;
    localparam int unsigned DATA_LSB_BIT = 20;

    typedef logic [11:0] coord_t;

endpackage

// File: rtl/spi_frame24.sv
// One 24-SCLK ADS7843 frame: command byte out MSB-first, 12-bit result captured on
// rising edges of bits 9..20, ss_n held high for one half-period before done.
module spi_frame24
    import touch_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] cmd_i,
    input  logic       miso_i,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       ss_n_o,
    output logic       done_o,
    output coord_t     data_o
);

    logic       active_q, active_d;
    logic [7:0] div_q, div_d;
    logic [5:0] half_q, half_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       ss_n_q, ss_n_d;
    logic       done_q, done_d;
    logic [7:0] cmd_q, cmd_d;
    coord_t     shreg_q, shreg_d;

    logic       wrap;
    logic [4:0] bit_idx;
    logic [4:0] nxt_idx;

    assign wrap    = (div_q == 8'(CLK_DIV - 1));
    assign bit_idx = half_q[5:1];
    assign nxt_idx = half_q[5:1] + 5'd1;

    // half_q counts elapsed half-periods; 0..47 are SCLK edges, 48 is the ss_n guard.
    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        half_d   = half_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        ss_n_d   = ss_n_q;
        done_d   = 1'b0;
        cmd_d    = cmd_q;
        shreg_d  = shreg_q;
        if (!active_q) begin
            div_d = '0;
            if (start_i) begin
                active_d = 1'b1;
                ss_n_d   = 1'b0;
                sclk_d   = 1'b0;
                half_d   = '0;
                cmd_d    = cmd_i;
                mosi_d   = cmd_i[7];
                shreg_d  = '0;
            end
        end else if (wrap) begin
            div_d  = '0;
            half_d = half_q + 6'd1;
            if (half_q < 6'(2 * FRAME_BITS)) begin
                sclk_d = ~sclk_q;
                if (!sclk_q) begin
                    if (bit_idx >= 5'(DATA_MSB_BIT) && bit_idx <= 5'(DATA_LSB_BIT))
                        shreg_d = {shreg_q[10:0], miso_i};
                end else begin
                    mosi_d = (nxt_idx < 5'd8) ? cmd_q[3'd7 - nxt_idx[2:0]] : 1'b0;
                    if (half_q == 6'(2 * FRAME_BITS - 1))
                        ss_n_d = 1'b1;
                end
            end else begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            div_q    <= '0;
            half_q   <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ss_n_q   <= 1'b1;
            done_q   <= 1'b0;
            cmd_q    <= '0;
            shreg_q  <= '0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            half_q   <= half_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            ss_n_q   <= ss_n_d;
            done_q   <= done_d;
            cmd_q    <= cmd_d;
            shreg_q  <= shreg_d;
        end
    end

    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    assign ss_n_o = ss_n_q;
    assign done_o = done_q;
    assign data_o = shreg_q;

endmodule

// File: rtl/touch_scan_ctrl.sv
// Autonomous pen-down debounce and X/Y scan sequencer for the LT24 touch ADC.
// Define TOUCH_SCAN_AVG_EN to average 4 pairs per coord_valid.
module touch_scan_ctrl
    import touch_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 25,
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned SCAN_GAP_CYC = 500000,
    parameter logic [7:0]  CMD_X        = 8'h90,
    parameter logic [7:0]  CMD_Y        = 8'hD0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pen_irq_n,
    input  logic        spi_miso,
    output logic        spi_mosi,
    output logic        spi_sclk,
    output logic        spi_ss_n,
    output logic        pen_down,
    output logic [11:0] coord_x,
    output logic [11:0] coord_y,
    output logic        coord_valid,
    output logic        busy
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CYC > SCAN_GAP_CYC) ? DEBOUNCE_CYC : SCAN_GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SCAN_GAP_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pen_meta_q, pen_sync_q;
    logic             pen_down_q, pen_down_d;
    coord_t           x_hold_q, x_hold_d;
    coord_t           coord_x_q, coord_x_d;
    coord_t           coord_y_q, coord_y_d;
    logic             valid_q, valid_d;
    logic             start;
    logic [7:0]       cmd;
    logic             done;
    coord_t           frame_data;
    logic             keep_going;

`ifdef TOUCH_SCAN_AVG_EN
    logic [13:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [1:0]  pairs_q, pairs_d;
    logic [13:0] sum_x, sum_y;
    assign sum_x = acc_x_q + {2'b00, x_hold_q};
    assign sum_y = acc_y_q + {2'b00, frame_data};
`endif

    assign keep_going = enable && !pen_sync_q;

    spi_frame24 #(.CLK_DIV(CLK_DIV)) u_frame (
        .clk    (clk),
        .reset  (reset),
        .start_i(start),
        .cmd_i  (cmd),
        .miso_i (spi_miso),
        .sclk_o (spi_sclk),
        .mosi_o (spi_mosi),
        .ss_n_o (spi_ss_n),
        .done_o (done),
        .data_o (frame_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pen_down_d = pen_down_q;
        x_hold_d   = x_hold_q;
        coord_x_d  = coord_x_q;
        coord_y_d  = coord_y_q;
        valid_d    = 1'b0;
        start      = 1'b0;
        cmd        = CMD_X;
`ifdef TOUCH_SCAN_AVG_EN
        acc_x_d    = acc_x_q;
        acc_y_d    = acc_y_q;
        pairs_d    = pairs_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                pen_down_d = 1'b0;
                if (keep_going)
                    state_d = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!keep_going) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d      = '0;
                    pen_down_d = 1'b1;
                    state_d    = FRAME_X;
                    start      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FRAME_X: begin
                if (done) begin
                    if (keep_going) begin
                        x_hold_d = frame_data;
                        state_d  = FRAME_Y;
                        start    = 1'b1;
                        cmd      = CMD_Y;
                    end else begin
                        state_d    = IDLE;
                        pen_down_d = 1'b0;
                    end
                end
            end
            FRAME_Y: begin
                if (done) begin
                    if (keep_going) begin
                        state_d = GAP;
                        cnt_d   = '0;
`ifdef TOUCH_SCAN_AVG_EN
                        if (pairs_q == 2'd3) begin
                            coord_x_d = sum_x[13:2];
                            coord_y_d = sum_y[13:2];
                            valid_d   = 1'b1;
                            acc_x_d   = '0;
                            acc_y_d   = '0;
                            pairs_d   = '0;
                        end else begin
                            acc_x_d = sum_x;
                            acc_y_d = sum_y;
                            pairs_d = pairs_q + 2'd1;
                        end
`else
                        coord_x_d = x_hold_q;
                        coord_y_d = frame_data;
                        valid_d   = 1'b1;
`endif
                    end else begin
                        state_d    = IDLE;
                        pen_down_d = 1'b0;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (keep_going) begin
                        state_d = FRAME_X;
                        start   = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        pen_down_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef TOUCH_SCAN_AVG_EN
        // Any return to IDLE ends the pen-down period, so partial sums are dropped.
        if (state_d == IDLE) begin
            acc_x_d = '0;
            acc_y_d = '0;
            pairs_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pen_meta_q <= 1'b1;
            pen_sync_q <= 1'b1;
            pen_down_q <= 1'b0;
            x_hold_q   <= '0;
            coord_x_q  <= '0;
            coord_y_q  <= '0;
            valid_q    <= 1'b0;
`ifdef TOUCH_SCAN_AVG_EN
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            pairs_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pen_meta_q <= pen_irq_n;
            pen_sync_q <= pen_meta_q;
            pen_down_q <= pen_down_d;
            x_hold_q   <= x_hold_d;
            coord_x_q  <= coord_x_d;
            coord_y_q  <= coord_y_d;
            valid_q    <= valid_d;
`ifdef TOUCH_SCAN_AVG_EN
            acc_x_q    <= acc_x_d;
            acc_y_q    <= acc_y_d;
            pairs_q    <= pairs_d;
`endif
        end
    end

    assign pen_down    = pen_down_q;
    assign coord_x     = coord_x_q;
    assign coord_y     = coord_y_q;
    assign coord_valid = valid_q;
    assign busy        = ~spi_ss_n;

endmodule
